// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and owner types for the IFU/LSU memory arbiter
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - 2-way request picker; MEM_ARB_RR_EN selects round-robin, else LSU priority
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_ifu_valid,
    input  logic       i_lsu_valid,
    input  arb_owner_e i_last_grant,
    output arb_owner_e o_winner
);

`ifdef MEM_ARB_RR_EN
    // On conflict the side that did not win last time goes first.
    always_comb begin
        if (i_ifu_valid && i_lsu_valid) begin
            o_winner = (i_last_grant == OWN_LSU) ? OWN_IFU : OWN_LSU;
        end else if (i_lsu_valid) begin
            o_winner = OWN_LSU;
        end else begin
            o_winner = OWN_IFU;
        end
    end
`else
    logic w_unused_pick;
    assign w_unused_pick = ^{i_ifu_valid, i_last_grant};

    always_comb begin
        o_winner = i_lsu_valid ? OWN_LSU : OWN_IFU;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between IFU and LSU (MEM_ARB_RR_EN: round-robin)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [XLEN-1:0]     ifu_req_addr,
    output logic                ifu_rsp_valid,
    output logic [XLEN-1:0]     ifu_rsp_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_req_write,
    input  logic [XLEN-1:0]     lsu_req_addr,
    input  logic [XLEN/8-1:0]   lsu_req_strobe,
    input  logic [XLEN-1:0]     lsu_req_wdata,
    input  logic [XLEN-1:0]     lsu_req_pc,
    output logic                lsu_rsp_valid,
    output logic [XLEN-1:0]     lsu_rsp_rdata,
    output logic                mem_valid,
    output logic                mem_write,
    output logic                mem_ifetch,
    output logic [XLEN-1:0]     mem_pc,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN/8-1:0]   mem_strobe,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT - 1);

    arb_state_e     r_state;
    arb_state_e     w_state_nxt;
    arb_owner_e     r_owner;
    arb_owner_e     r_last_grant;
    arb_owner_e     w_winner;
    logic [CW-1:0]  r_lat_cnt;
    logic           w_any_req;
    logic           w_grant;
    logic           w_rsp;

    mem_arb_pick u_pick (
        .i_ifu_valid  (ifu_req_valid),
        .i_lsu_valid  (lsu_req_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner)
    );

    // Outputs are qualified by !rst so a reset in the response cycle yields no pulse.
    assign w_any_req = ifu_req_valid || lsu_req_valid;
    assign w_grant   = !rst && (r_state == ARB_IDLE) && w_any_req;
    assign w_rsp     = !rst && (r_state == ARB_WAIT) && (r_lat_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_any_req) w_state_nxt = ARB_WAIT;
            ARB_WAIT: if (r_lat_cnt == '0) w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_IFU;
            r_lat_cnt    <= '0;
            r_last_grant <= OWN_LSU;
        end else if (w_grant) begin
            r_owner      <= w_winner;
            r_lat_cnt    <= LAT_INIT;
            r_last_grant <= w_winner;
        end else if ((r_state == ARB_WAIT) && (r_lat_cnt != '0)) begin
            r_lat_cnt    <= r_lat_cnt - 1'b1;
        end
    end

    always_comb begin
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        mem_valid     = 1'b0;
        mem_write     = 1'b0;
        mem_ifetch    = 1'b0;
        mem_pc        = '0;
        mem_addr      = '0;
        mem_strobe    = '0;
        mem_wdata     = '0;
        if (w_grant) begin
            mem_valid = 1'b1;
            if (w_winner == OWN_IFU) begin
                ifu_req_ready = 1'b1;
                mem_ifetch    = 1'b1;
                mem_addr      = ifu_req_addr;
                mem_pc        = ifu_req_addr;
            end else begin
                lsu_req_ready = 1'b1;
                mem_write     = lsu_req_write;
                mem_addr      = lsu_req_addr;
                mem_strobe    = lsu_req_strobe;
                mem_wdata     = lsu_req_wdata;
                mem_pc        = lsu_req_pc;
            end
        end
        if (w_rsp) begin
            ifu_rsp_valid = (r_owner == OWN_IFU);
            lsu_rsp_valid = (r_owner == OWN_LSU);
        end
    end

    assign ifu_rsp_rdata = mem_rdata;
    assign lsu_rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr = '0;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_rdata;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic        lsu_req_write = 1'b0;
    logic [31:0] lsu_req_addr = '0;
    logic [3:0]  lsu_req_strobe = '0;
    logic [31:0] lsu_req_wdata = '0;
    logic [31:0] lsu_req_pc = '0;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_rdata;
    logic        mem_valid, mem_write, mem_ifetch;
    logic [31:0] mem_pc, mem_addr, mem_wdata;
    logic [3:0]  mem_strobe;
    logic [31:0] mem_rdata = '0;

    logic        ifu_req_valid3 = 1'b0;
    logic        ifu_req_ready3;
    logic        ifu_rsp_valid3;
    logic [31:0] ifu_rsp_rdata3;
    logic        lsu_req_ready3, lsu_rsp_valid3;
    logic [31:0] lsu_rsp_rdata3;
    logic        mem_valid3, mem_write3, mem_ifetch3;
    logic [31:0] mem_pc3, mem_addr3, mem_wdata3;
    logic [3:0]  mem_strobe3;
    logic [31:0] mem_rdata3 = 32'hCAFE_0000;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = '0;
    logic [3:0]  zero_strb = '0;

    int n_total = 0;
    int n_bad   = 0;

    mem_arbiter #(.XLEN(32), .MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_write(lsu_req_write),
        .lsu_req_addr(lsu_req_addr), .lsu_req_strobe(lsu_req_strobe), .lsu_req_wdata(lsu_req_wdata),
        .lsu_req_pc(lsu_req_pc), .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_ifetch(mem_ifetch), .mem_pc(mem_pc),
        .mem_addr(mem_addr), .mem_strobe(mem_strobe), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.XLEN(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid3), .ifu_req_ready(ifu_req_ready3), .ifu_req_addr(32'h8000_0000),
        .ifu_rsp_valid(ifu_rsp_valid3), .ifu_rsp_rdata(ifu_rsp_rdata3),
        .lsu_req_valid(zero_bit), .lsu_req_ready(lsu_req_ready3), .lsu_req_write(zero_bit),
        .lsu_req_addr(zero_word), .lsu_req_strobe(zero_strb), .lsu_req_wdata(zero_word),
        .lsu_req_pc(zero_word), .lsu_rsp_valid(lsu_rsp_valid3), .lsu_rsp_rdata(lsu_rsp_rdata3),
        .mem_valid(mem_valid3), .mem_write(mem_write3), .mem_ifetch(mem_ifetch3), .mem_pc(mem_pc3),
        .mem_addr(mem_addr3), .mem_strobe(mem_strobe3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset: requests must be ignored while rst is high
        tick();
        tick();
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        mem_rdata     = 32'h0000_0413;
        #1;
        chk("rst_ifu_ready", ifu_req_ready, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_ifu_rsp",   ifu_rsp_valid, 0);
        tick();

        // 1: IFU fetch
        rst = 1'b0;
        #1;
        chk("t1_ifu_ready", ifu_req_ready, 1);
        chk("t1_lsu_ready", lsu_req_ready, 0);
        chk("t1_mem_valid", mem_valid, 1);
        chk("t1_ifetch",    mem_ifetch, 1);
        chk("t1_addr",      mem_addr, 32'h8000_0000);
        chk("t1_pc",        mem_pc, 32'h8000_0000);
        chk("t1_write",     mem_write, 0);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("t1_rsp_valid", ifu_rsp_valid, 1);
        chk("t1_rsp_rdata", ifu_rsp_rdata, 32'h0000_0413);
        chk("t1_wait_memv", mem_valid, 0);
        chk("t1_lsu_rsp",   lsu_rsp_valid, 0);
        tick();
        #1;
        chk("t1_idle_rsp",  ifu_rsp_valid, 0);
        chk("t1_idle_addr", mem_addr, 0);

        // 2: LSU store
        lsu_req_valid  = 1'b1;
        lsu_req_write  = 1'b1;
        lsu_req_addr   = 32'h8000_0100;
        lsu_req_wdata  = 32'hDEAD_BEEF;
        lsu_req_strobe = 4'b0011;
        lsu_req_pc     = 32'h8000_0040;
        #1;
        chk("t2_lsu_ready", lsu_req_ready, 1);
        chk("t2_ifu_ready", ifu_req_ready, 0);
        chk("t2_write",     mem_write, 1);
        chk("t2_addr",      mem_addr, 32'h8000_0100);
        chk("t2_wdata",     mem_wdata, 32'hDEAD_BEEF);
        chk("t2_strobe",    mem_strobe, 4'b0011);
        chk("t2_pc",        mem_pc, 32'h8000_0040);
        chk("t2_ifetch",    mem_ifetch, 0);
        tick();
        lsu_req_valid = 1'b0;
        lsu_req_write = 1'b0;
        #1;
        chk("t2_lsu_rsp",   lsu_rsp_valid, 1);
        chk("t2_ifu_rsp",   ifu_rsp_valid, 0);
        chk("t2_wait_wr",   mem_write, 0);
        tick();

`ifdef MEM_ARB_RR_EN
        // 4: round-robin from reset, both requesting continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0010;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_0300;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("t4_ifu_ready", ifu_req_ready, (g % 2 == 0) ? 1 : 0);
            chk("t4_lsu_ready", lsu_req_ready, (g % 2 == 1) ? 1 : 0);
            tick();
            tick();
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        #1;
`else
        // 3: conflict under fixed priority
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0008;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_0200;
        #1;
        chk("t3_lsu_ready", lsu_req_ready, 1);
        chk("t3_ifu_ready", ifu_req_ready, 0);
        chk("t3_addr_lsu",  mem_addr, 32'h8000_0200);
        tick();
        lsu_req_valid = 1'b0;
        #1;
        chk("t3_lsu_rsp",   lsu_rsp_valid, 1);
        chk("t3_ifu_wait",  ifu_req_ready, 0);
        chk("t3_ifu_rsp0",  ifu_rsp_valid, 0);
        tick();
        #1;
        chk("t3_ifu_ready2", ifu_req_ready, 1);
        chk("t3_addr_ifu",   mem_addr, 32'h8000_0008);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("t3_ifu_rsp",    ifu_rsp_valid, 1);
        tick();
`endif

        // 5: reset during WAIT abandons the response
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0020;
        #1;
        chk("t5_grant", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_rst_rsp",  ifu_rsp_valid, 0);
        chk("t5_rst_lrsp", lsu_rsp_valid, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_idle_rsp",  ifu_rsp_valid, 0);
        chk("t5_idle_memv", mem_valid, 0);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0004;
        mem_rdata     = 32'h0040_0093;
        #1;
        chk("t5_regrant", ifu_req_ready, 1);
        chk("t5_addr",    mem_addr, 32'h8000_0004);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("t5_rsp",       ifu_rsp_valid, 1);
        chk("t5_rsp_rdata", ifu_rsp_rdata, 32'h0040_0093);
        tick();

        // 6: MEM_LAT=3, IFU requesting back to back
        ifu_req_valid3 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("t6_memv",  mem_valid3,     (k % 4 == 0) ? 1 : 0);
            chk("t6_ready", ifu_req_ready3, (k % 4 == 0) ? 1 : 0);
            chk("t6_rsp",   ifu_rsp_valid3, (k % 4 == 3) ? 1 : 0);
            if (k % 4 == 3) chk("t6_rdata", ifu_rsp_rdata3, 32'hCAFE_0000);
            tick();
        end
        ifu_req_valid3 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
